hba_arbiter: RTL and testbench
==============================

HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (legal 2..4).
REQ-002 SHALL have parameter DBUS_WIDTH, default 8, HBA data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, HBA address width (4-bit peripheral + 8-bit register).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit in clocks while waiting for xferack.
REQ-005 SHALL have port hba_clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port hba_reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port master_req  in  NUM_MASTERS  per-master transfer request, held until master_ack.
REQ-008 SHALL have port master_rnw  in  NUM_MASTERS  per-master direction, 1=read, 0=write.
REQ-009 SHALL have port master_abus  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i.
REQ-010 SHALL have port master_dbus  in  NUM_MASTERS*DBUS_WIDTH  per-master write data, master i at slice i.
REQ-011 SHALL have port master_grant  out  NUM_MASTERS  one-hot owner of the bus, or zero.
REQ-012 SHALL have port master_ack  out  NUM_MASTERS  one-cycle completion pulse to the owner.
REQ-013 SHALL have port master_rdata  out  DBUS_WIDTH  read data captured at completion.
REQ-014 SHALL have port master_err  out  1  pulses with master_ack when a transfer timed out.
REQ-015 SHALL have ports hba_rnw, hba_select (out, 1), hba_abus (out, ADDR_WIDTH) and hba_dbus (out, DBUS_WIDTH), which drive the HBA bus to the slaves.
REQ-016 SHALL have port hba_xferack  in  1  OR of all slave xferacks.
REQ-017 SHALL have port hba_rdbus  in  DBUS_WIDTH  OR of all slave output data buses.

Function
REQ-018 SHALL implement states IDLE, XFER, RELEASE.
REQ-019 In IDLE with any master_req high, SHALL pick the winner round-robin, starting from the master after last_owner. It SHALL go to XFER on the next edge.
REQ-020 On entry to XFER, SHALL register the winner's rnw, abus and dbus onto the hba_* outputs, set hba_select=1 and set the winner's master_grant bit (grant latency 1 clock after req is sampled).
REQ-021 hba_rnw, hba_abus, hba_dbus and master_grant SHALL hold stable throughout XFER and RELEASE, even if the master's inputs change.
REQ-022 In XFER with hba_xferack=1, SHALL do the following on that edge: capture hba_rdbus into master_rdata (reads only; writes leave it unchanged), pulse master_ack for the owner, clear hba_select, and go to RELEASE.
REQ-023 In RELEASE, SHALL wait for hba_xferack=0, then clear master_grant, record last_owner and go to IDLE. The minimum request-to-request turnaround SHALL be 1 idle cycle.
REQ-024 A master that drops master_req while granted SHALL NOT abort the transfer.
REQ-025 When all masters request simultaneously, every master SHALL be served within NUM_MASTERS transfers.
REQ-026 hba_abus and hba_dbus SHALL be driven to zero whenever hba_select=0 in IDLE, so the bus is OR-safe.

Reset
REQ-027 When hba_reset=0 at a clock edge, SHALL enter IDLE with all outputs zero and last_owner = NUM_MASTERS-1, so that master 0 wins first.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer: no master_ack is issued and hba_select is 0 on the next edge.

Configuration
REQ-029 With macro HBA_ARBITER_TIMEOUT_EN defined, a counter SHALL run in XFER. If TIMEOUT_CYCLES clocks elapse with no hba_xferack, SHALL pulse master_ack and master_err, leave master_rdata unchanged, clear hba_select and go directly to IDLE.
REQ-030 Without HBA_ARBITER_TIMEOUT_EN, XFER SHALL wait indefinitely and master_err SHALL be tied to 0.

Verification
REQ-031 Master 0 writes 12'h501 = 8'h12, with a slave model acking 2 cycles after select -> grant=4'b0001 one cycle after req; hba_abus=12'h501, hba_dbus=8'h12 while select is high; one master_ack pulse.
REQ-032 Master 2 reads 12'h501 and the slave returns 8'h12 -> master_rdata=8'h12 on master_ack; select is low the cycle after ack.
REQ-033 All four masters request at once, each repeating -> grants in order 0,1,2,3,0; no master is granted twice before all others.
REQ-034 Reset driven low while XFER is waiting on ack -> next edge has select=0 and grant=0, no ack; after release, master 0 wins first.
REQ-035 With HBA_ARBITER_TIMEOUT_EN defined, a slave that never acks -> master_ack and master_err pulse together exactly 16 clocks after select rises, then IDLE; without the macro, select stays high.
REQ-036 Slave holds xferack high for 3 cycles -> arbiter remains in RELEASE and the next grant begins only after xferack falls.

Source files
------------

// File: rtl/hba_arbiter_if.sv
// HBA arbiter bundle: per-master request side plus the shared HBA slave bus.
// Modport master is the arbiter (it masters the HBA bus); modport slave is its environment.
interface hba_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DBUS_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12
);
  logic [NUM_MASTERS-1:0]            master_req;
  logic [NUM_MASTERS-1:0]            master_rnw;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus;
  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus;
  logic [NUM_MASTERS-1:0]            master_grant;
  logic [NUM_MASTERS-1:0]            master_ack;
  logic [DBUS_WIDTH-1:0]             master_rdata;
  logic                              master_err;
  logic                              hba_rnw;
  logic                              hba_select;
  logic [ADDR_WIDTH-1:0]             hba_abus;
  logic [DBUS_WIDTH-1:0]             hba_dbus;
  logic                              hba_xferack;
  logic [DBUS_WIDTH-1:0]             hba_rdbus;

  modport master (
    input  master_req, master_rnw, master_abus, master_dbus, hba_xferack, hba_rdbus,
    output master_grant, master_ack, master_rdata, master_err,
           hba_rnw, hba_select, hba_abus, hba_dbus
  );

  modport slave (
    output master_req, master_rnw, master_abus, master_dbus, hba_xferack, hba_rdbus,
    input  master_grant, master_ack, master_rdata, master_err,
           hba_rnw, hba_select, hba_abus, hba_dbus
  );
endinterface

// File: rtl/hba_arbiter.sv
// Round-robin arbiter granting one of NUM_MASTERS requesters access to the HBA slave bus.
// Define HBA_ARBITER_TIMEOUT_EN to enable the xferack watchdog (master_err on timeout).
module hba_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DBUS_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          hba_clk,
  input  logic          hba_reset,
  hba_arbiter_if.master bus
);
  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t                 state_q;
  logic [OW-1:0]          owner_q;
  logic [OW-1:0]          last_owner_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [DBUS_WIDTH-1:0]  rdata_q;
  logic                   rnw_q;
  logic                   select_q;
  logic [ADDR_WIDTH-1:0]  abus_q;
  logic [DBUS_WIDTH-1:0]  dbus_q;

  logic                   win_vld;
  logic [OW-1:0]          win_idx;
  logic [OW:0]            rr_sum;
  logic                   sel_rnw;
  logic [ADDR_WIDTH-1:0]  sel_abus;
  logic [DBUS_WIDTH-1:0]  sel_dbus;

  // Scan downward so the candidate closest after last_owner is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      rr_sum = {1'b0, last_owner_q} + (OW+1)'(k);
      if (rr_sum >= (OW+1)'(NUM_MASTERS)) rr_sum = rr_sum - (OW+1)'(NUM_MASTERS);
      if (bus.master_req[rr_sum[OW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = rr_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    sel_rnw  = 1'b0;
    sel_abus = '0;
    sel_dbus = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_idx == OW'(i)) begin
        sel_rnw  = bus.master_rnw[i];
        sel_abus = bus.master_abus[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dbus = bus.master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

`ifdef HBA_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_MASTERS - 1);
      grant_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rnw_q        <= 1'b0;
      select_q     <= 1'b0;
      abus_q       <= '0;
      dbus_q       <= '0;
`ifdef HBA_ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef HBA_ARBITER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q  <= XFER;
            owner_q  <= win_idx;
            grant_q  <= NUM_MASTERS'(1) << win_idx;
            select_q <= 1'b1;
            rnw_q    <= sel_rnw;
            abus_q   <= sel_abus;
            dbus_q   <= sel_dbus;
`ifdef HBA_ARBITER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        XFER: begin
          if (bus.hba_xferack) begin
            if (rnw_q) rdata_q <= bus.hba_rdbus;
            ack_q    <= grant_q;
            select_q <= 1'b0;
            state_q  <= RELEASE;
          end
`ifdef HBA_ARBITER_TIMEOUT_EN
          // Watchdog: abandon the slave and return straight to IDLE with an error ack.
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            ack_q        <= grant_q;
            err_q        <= 1'b1;
            select_q     <= 1'b0;
            grant_q      <= '0;
            last_owner_q <= owner_q;
            rnw_q        <= 1'b0;
            abus_q       <= '0;
            dbus_q       <= '0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        RELEASE: begin
          // Bus outputs return to zero on leaving so the OR-combined HBA bus stays clean.
          if (!bus.hba_xferack) begin
            grant_q      <= '0;
            last_owner_q <= owner_q;
            rnw_q        <= 1'b0;
            abus_q       <= '0;
            dbus_q       <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.master_grant = grant_q;
  assign bus.master_ack   = ack_q;
  assign bus.master_rdata = rdata_q;
  assign bus.hba_rnw      = rnw_q;
  assign bus.hba_select   = select_q;
  assign bus.hba_abus     = abus_q;
  assign bus.hba_dbus     = dbus_q;
`ifdef HBA_ARBITER_TIMEOUT_EN
  assign bus.master_err   = err_q;
`else
  assign bus.master_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hba_arbiter.sv
// Self-checking bench for hba_arbiter: directed scenarios plus a randomized run
// against a round-robin reference model with a configurable slave model.
module tb_hba_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic hba_clk = 1'b0;
  logic hba_reset;
  always #5 hba_clk = ~hba_clk;

  hba_arbiter_if #(.NUM_MASTERS(N), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  hba_arbiter #(.NUM_MASTERS(N), .DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .hba_clk  (hba_clk),
    .hba_reset(hba_reset),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave model: raise xferack ack_delay clocks after select rises, hold it ack_hold clocks.
  int ack_delay = 2;
  int ack_hold  = 1;
  int sel_cnt   = 0;
  int hold_left = 0;
  bit no_ack    = 1'b0;
  logic [DW-1:0] slave_data = '0;

  always @(negedge hba_clk) begin
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        bus.hba_xferack = 1'b0;
        bus.hba_rdbus   = '0;
        sel_cnt         = 0;
      end
    end else if (bus.hba_select === 1'b1) begin
      sel_cnt++;
      if (!no_ack && sel_cnt == ack_delay) begin
        bus.hba_xferack = 1'b1;
        bus.hba_rdbus   = slave_data;
        hold_left       = ack_hold;
      end
    end else begin
      sel_cnt = 0;
    end
  end

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(negedge hba_clk);
  endtask

  task automatic set_master(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.master_rnw[i]             = rnw;
    bus.master_abus[i*AW +: AW]   = a;
    bus.master_dbus[i*DW +: DW]   = d;
  endtask

  task automatic do_reset();
    hba_reset      = 1'b0;
    bus.master_req = '0;
    repeat (4) tick();
    hba_reset = 1'b1;
  endtask

  task automatic test_reset();
    hba_reset      = 1'b0;
    bus.master_req = '1;
    repeat (3) tick();
    checks++; if (bus.master_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bus.master_grant); end
    checks++; if (bus.master_ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.master_ack); end
    checks++; if (bus.hba_select !== 1'b0) begin errors++; $display("FAIL reset_select: got %b expected 0", bus.hba_select); end
    checks++; if (bus.hba_abus !== '0) begin errors++; $display("FAIL reset_abus: got %h expected 0", bus.hba_abus); end
    checks++; if (bus.hba_dbus !== '0) begin errors++; $display("FAIL reset_dbus: got %h expected 0", bus.hba_dbus); end
    checks++; if (bus.hba_rnw !== 1'b0) begin errors++; $display("FAIL reset_rnw: got %b expected 0", bus.hba_rnw); end
    checks++; if (bus.master_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.master_rdata); end
    checks++; if (bus.master_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.master_err); end
    bus.master_req = '0;
  endtask

  task automatic test_write();
    int n_ack = 0;
    int ack_cyc = -1;
    do_reset();
    no_ack = 1'b0; ack_delay = 2; ack_hold = 1;
    set_master(0, 1'b0, 12'h501, 8'h12);
    bus.master_req[0] = 1'b1;
    tick();
    checks++; if (bus.master_grant !== 4'b0001 || bus.hba_select !== 1'b1 || bus.hba_rnw !== 1'b0)
      begin errors++; $display("FAIL wr_grant: got grant=%b sel=%b rnw=%b expected 0001/1/0", bus.master_grant, bus.hba_select, bus.hba_rnw); end
    for (int c = 0; c < 12; c++) begin
      if (bus.hba_select === 1'b1) begin
        checks++; if (bus.hba_abus !== 12'h501 || bus.hba_dbus !== 8'h12)
          begin errors++; $display("FAIL wr_bus: got %h/%h expected 501/12", bus.hba_abus, bus.hba_dbus); end
      end
      if (bus.master_ack !== '0) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        checks++; if (bus.master_ack !== 4'b0001 || bus.master_err !== 1'b0)
          begin errors++; $display("FAIL wr_ack: got ack=%b err=%b expected 0001/0", bus.master_ack, bus.master_err); end
        bus.master_req[0] = 1'b0;
      end
      tick();
    end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL wr_ack_count: got %0d expected 1", n_ack); end
    checks++; if (ack_cyc != 2) begin errors++; $display("FAIL wr_ack_latency: got %0d expected 2", ack_cyc); end
  endtask

  task automatic test_read();
    int c = 0;
    do_reset();
    no_ack = 1'b0; ack_delay = 2; ack_hold = 1; slave_data = 8'h12;
    set_master(2, 1'b1, 12'h501, 8'h00);
    bus.master_req[2] = 1'b1;
    tick();
    checks++; if (bus.master_grant !== 4'b0100 || bus.hba_rnw !== 1'b1 || bus.hba_abus !== 12'h501)
      begin errors++; $display("FAIL rd_grant: got %b rnw=%b abus=%h expected 0100/1/501", bus.master_grant, bus.hba_rnw, bus.hba_abus); end
    while (bus.master_ack === '0 && c < 12) begin tick(); c++; end
    checks++;
    if (c >= 12) begin errors++; $display("FAIL rd_ack_timeout: got no ack expected ack within 12 cycles"); end
    else if (bus.master_ack !== 4'b0100 || bus.master_rdata !== 8'h12 || bus.hba_select !== 1'b0)
      begin errors++; $display("FAIL rd_ack: got ack=%b rdata=%h sel=%b expected 0100/12/0", bus.master_ack, bus.master_rdata, bus.hba_select); end
    bus.master_req[2] = 1'b0;
    tick();
    checks++; if (bus.hba_select !== 1'b0 || bus.master_rdata !== 8'h12)
      begin errors++; $display("FAIL rd_after: got sel=%b rdata=%h expected 0/12", bus.hba_select, bus.master_rdata); end
  endtask

  task automatic test_drop_req();
    int ack_cyc = -1;
    do_reset();
    no_ack = 1'b0; ack_delay = 3; ack_hold = 1;
    set_master(1, 1'b0, 12'h3A5, 8'h5C);
    bus.master_req[1] = 1'b1;
    tick();
    checks++; if (bus.master_grant !== 4'b0010) begin errors++; $display("FAIL drop_grant: got %b expected 0010", bus.master_grant); end
    bus.master_req[1] = 1'b0;
    set_master(1, 1'b1, 12'hFFF, 8'hFF);
    for (int c = 0; c < 12; c++) begin
      if (bus.master_grant !== '0) begin
        checks++; if (bus.hba_abus !== 12'h3A5 || bus.hba_dbus !== 8'h5C || bus.hba_rnw !== 1'b0)
          begin errors++; $display("FAIL drop_stable: got %h/%h/%b expected 3A5/5C/0", bus.hba_abus, bus.hba_dbus, bus.hba_rnw); end
      end
      if (bus.master_ack !== '0 && ack_cyc < 0) begin
        ack_cyc = c;
        checks++; if (bus.master_ack !== 4'b0010) begin errors++; $display("FAIL drop_ack: got %b expected 0010", bus.master_ack); end
      end
      tick();
    end
    checks++; if (ack_cyc != 3) begin errors++; $display("FAIL drop_ack_cycle: got %0d expected 3", ack_cyc); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int c = 0;
    do_reset();
    no_ack = 1'b0; ack_delay = 1; ack_hold = 1;
    for (int i = 0; i < N; i++) set_master(i, 1'b0, AW'(12'h100 + i), DW'(8'h40 + i));
    bus.master_req = '1;
    while (order.size() < 5 && c < 200) begin
      tick(); c++;
      if (bus.master_ack !== '0) order.push_back(onehot_idx(bus.master_ack));
    end
    bus.master_req = '0;
    checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_count: got %0d acks expected 5", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++; if (order[k] != k % N) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], k % N); end
    end
  endtask

  task automatic test_long_ack();
    logic [N-1:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    logic         exp_s [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] exp_a [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    no_ack = 1'b0; ack_delay = 1; ack_hold = 3;
    set_master(0, 1'b0, 12'h210, 8'hA0);
    set_master(1, 1'b0, 12'h311, 8'hB1);
    bus.master_req = 4'b0011;
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.master_grant !== exp_g[c] || bus.hba_select !== exp_s[c] || bus.master_ack !== exp_a[c])
        begin errors++; $display("FAIL long_ack[%0d]: got g=%b s=%b a=%b expected g=%b s=%b a=%b", c,
          bus.master_grant, bus.hba_select, bus.master_ack, exp_g[c], exp_s[c], exp_a[c]); end
      if (bus.master_ack[0] === 1'b1) bus.master_req[0] = 1'b0;
      tick();
    end
    bus.master_req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    no_ack = 1'b1;
    set_master(1, 1'b0, 12'h0AA, 8'h55);
    bus.master_req[1] = 1'b1;
    tick();
    checks++; if (bus.master_grant !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b expected 0010", bus.master_grant); end
    repeat (3) tick();
    hba_reset = 1'b0;
    tick();
    checks++; if (bus.hba_select !== 1'b0 || bus.master_grant !== '0 || bus.master_ack !== '0)
      begin errors++; $display("FAIL mid_reset: got s=%b g=%b a=%b expected 0/0/0", bus.hba_select, bus.master_grant, bus.master_ack); end
    hba_reset = 1'b1;
    for (int i = 0; i < N; i++) set_master(i, 1'b0, AW'(12'h700 + i), DW'(i));
    bus.master_req = '1;
    tick();
    checks++; if (bus.master_grant !== 4'b0001) begin errors++; $display("FAIL mid_first: got %b expected 0001", bus.master_grant); end
    bus.master_req = '0;
  endtask

  task automatic test_timeout();
    int ack_cyc = -1;
    int n_ack = 0;
    do_reset();
    no_ack = 1'b1;
    set_master(3, 1'b1, 12'h5FF, 8'h00);
    bus.master_req[3] = 1'b1;
    tick();
`ifdef HBA_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      if (bus.master_ack !== '0) begin
        ack_cyc = c;
        checks++; if (bus.master_ack !== 4'b1000 || bus.master_err !== 1'b1 || bus.hba_select !== 1'b0 ||
                      bus.master_grant !== '0 || bus.master_rdata !== '0)
          begin errors++; $display("FAIL to_ack: got a=%b e=%b s=%b g=%b rd=%h expected 1000/1/0/0/00",
            bus.master_ack, bus.master_err, bus.hba_select, bus.master_grant, bus.master_rdata); end
        bus.master_req[3] = 1'b0;
      end
      tick();
    end
    checks++; if (ack_cyc != TO) begin errors++; $display("FAIL to_cycle: got %0d expected %0d", ack_cyc, TO); end
    checks++; if (bus.master_ack !== '0 || bus.master_err !== 1'b0)
      begin errors++; $display("FAIL to_pulse: got a=%b e=%b expected 0/0", bus.master_ack, bus.master_err); end
`else
    for (int c = 0; c < 40; c++) begin
      if (bus.master_ack !== '0 || bus.master_err !== 1'b0) n_ack++;
      tick();
    end
    checks++; if (bus.hba_select !== 1'b1 || bus.master_grant !== 4'b1000)
      begin errors++; $display("FAIL to_wait: got s=%b g=%b expected 1/1000", bus.hba_select, bus.master_grant); end
    checks++; if (n_ack != 0 || ack_cyc != -1) begin errors++; $display("FAIL to_noack: got %0d acks expected 0", n_ack); end
`endif
    bus.master_req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]  pend = '0;
    logic          t_rnw  [N];
    logic [AW-1:0] t_abus [N];
    logic [DW-1:0] t_dbus [N];
    logic [DW-1:0] rd_model = '0;
    int  last = N - 1;
    int  cur = 0;
    int  exp;
    int  n_done = 0;
    bit  granted = 1'b0;
    bit  acked = 1'b0;
    do_reset();
    no_ack = 1'b0;
    ack_delay  = $urandom_range(1, 4);
    ack_hold   = $urandom_range(1, 2);
    slave_data = DW'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!granted && bus.master_grant !== '0) begin
        exp = rr_pick(pend, last);
        checks++; if (exp < 0 || bus.master_grant !== (N'(1) << exp) || bus.hba_select !== 1'b1)
          begin errors++; $display("FAIL rnd_winner: got g=%b s=%b expected master %0d", bus.master_grant, bus.hba_select, exp); end
        cur = (exp < 0) ? 0 : exp;
        granted = 1'b1;
        acked   = 1'b0;
      end
      if (granted) begin
        if (bus.master_grant === '0) granted = 1'b0;
        else begin
          checks++; if (bus.master_grant !== (N'(1) << cur) || bus.hba_rnw !== t_rnw[cur] ||
                        bus.hba_abus !== t_abus[cur] || bus.hba_dbus !== t_dbus[cur])
            begin errors++; $display("FAIL rnd_hold: got g=%b rnw=%b a=%h d=%h expected m%0d rnw=%b a=%h d=%h",
              bus.master_grant, bus.hba_rnw, bus.hba_abus, bus.hba_dbus, cur, t_rnw[cur], t_abus[cur], t_dbus[cur]); end
          if (!acked) set_master(cur, ~t_rnw[cur], AW'($urandom), DW'($urandom));
        end
      end
      if (bus.master_ack !== '0) begin
        checks++; if (!granted || acked || bus.master_ack !== (N'(1) << cur))
          begin errors++; $display("FAIL rnd_ack: got %b expected single pulse for master %0d", bus.master_ack, cur); end
        if (granted && !acked) begin
          acked = 1'b1;
          if (t_rnw[cur]) rd_model = slave_data;
          checks++; if (bus.master_rdata !== rd_model)
            begin errors++; $display("FAIL rnd_rdata: got %h expected %h", bus.master_rdata, rd_model); end
          pend[cur] = 1'b0;
          bus.master_req[cur] = 1'b0;
          last = cur;
          n_done++;
          slave_data = DW'($urandom);
          ack_delay  = $urandom_range(1, 4);
          ack_hold   = $urandom_range(1, 2);
        end
      end
      if (bus.master_grant === '0) begin
        checks++; if (bus.hba_select !== 1'b0 || bus.hba_abus !== '0 || bus.hba_dbus !== '0)
          begin errors++; $display("FAIL rnd_idle_bus: got s=%b a=%h d=%h expected 0/0/0", bus.hba_select, bus.hba_abus, bus.hba_dbus); end
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !(granted && i == cur) && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          t_rnw[i]  = 1'($urandom);
          t_abus[i] = AW'($urandom);
          t_dbus[i] = DW'($urandom);
          set_master(i, t_rnw[i], t_abus[i], t_dbus[i]);
          bus.master_req[i] = 1'b1;
        end
      end
    end
    checks++; if (n_done < 50) begin errors++; $display("FAIL rnd_progress: got %0d transfers expected at least 50", n_done); end
    bus.master_req = '0;
  endtask

  initial begin
    hba_reset        = 1'b0;
    bus.master_req   = '0;
    bus.master_rnw   = '0;
    bus.master_abus  = '0;
    bus.master_dbus  = '0;
    bus.hba_xferack  = 1'b0;
    bus.hba_rdbus    = '0;
    test_reset();
    test_write();
    test_read();
    test_drop_req();
    test_round_robin();
    test_long_ack();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
